rom_arbiter: RTL and testbench

Shares the single combinational-read instruction ROM between two requesters: the instruction-fetch port (IF) and a data-load port (D) for constant data in ROM. Each cycle, at most one request is granted and drives the ROM address. The read word is aligned and extended per request size, then returned one cycle later through a registered response. The block sits between the fetch/memory stages and the ROM in the multi-cycle and pipelined core variants.

---
 rtl/rom_arbiter_pkg.sv | 34 +++
 rtl/rom_arbiter_if.sv | 43 ++++
 rtl/rom_arbiter_align.sv | 67 ++++++
 rtl/rom_arbiter.sv | 105 ++++++++++
 tb/tb_rom_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the instruction/constant ROM path: address geometry,
// access sizes and the request record presented to the load aligner.
package DEF;

    localparam int ROM_ADDR_W = 13;
    localparam int ROM_BYTES  = 8192;

    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } rom_size_e;

    typedef struct packed {
        logic [ROM_ADDR_W-1:0] addr;
        rom_size_e             size;
        logic                  is_unsigned;
    } rom_req_t;

    // Byte count of an access; the illegal size reports a full word so the
    // range check stays well defined.
    function automatic logic [2:0] size_bytes(input rom_size_e size);
        case (size)
            SZ_B:    size_bytes = 3'd1;
            SZ_H:    size_bytes = 3'd2;
            SZ_W:    size_bytes = 3'd4;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the fetch/load stages, the ROM and the
// arbiter. master = requesters plus ROM, slave = arbiter.
interface rom_arbiter_if;
    import DEF::*;

    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ROM_ADDR_W-1:0] if_req_addr;
    logic                  if_rsp_valid;
    word                   if_rsp_data;
    logic                  if_rsp_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [ROM_ADDR_W-1:0] d_req_addr;
    logic [1:0]            d_req_size;
    logic                  d_req_unsigned;
    logic                  d_rsp_valid;
    word                   d_rsp_data;
    logic                  d_rsp_err;

    logic [ROM_ADDR_W-1:0] rom_addr;
    word                   rom_r_data;

    modport master (
        output if_req_valid, if_req_addr,
        output d_req_valid, d_req_addr, d_req_size, d_req_unsigned,
        output rom_r_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  rom_addr
    );

    modport slave (
        input  if_req_valid, if_req_addr,
        input  d_req_valid, d_req_addr, d_req_size, d_req_unsigned,
        input  rom_r_data,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output rom_addr
    );

endinterface

// File: rtl/rom_arbiter_align.sv
// Combinational lane select, sign/zero extension and alignment/range check
// for one granted ROM request. Instruction fetches arrive as unsigned words.
module rom_load_align
    import DEF::*;
(
    input  rom_req_t req,
    input  word      rom_data,
    output word      data,
    output logic     err
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [13:0] last_s;
    word         ext_s;
    logic        misalign_s;

    // Extract the addressed lane, extend it and flag illegal accesses.
    always_comb begin
        case (req.addr[1:0])
            2'b00:   byte_s = rom_data[7:0];
            2'b01:   byte_s = rom_data[15:8];
            2'b10:   byte_s = rom_data[23:16];
            2'b11:   byte_s = rom_data[31:24];
            default: byte_s = rom_data[7:0];
        endcase

        if (req.addr[1]) begin
            half_s = rom_data[31:16];
        end else begin
            half_s = rom_data[15:0];
        end

        // One extra bit so an access running off the end of ROM is visible.
        last_s = {1'b0, req.addr} + {11'b0, size_bytes(req.size)} - 14'd1;

        case (req.size)
            SZ_B: begin
                misalign_s = 1'b0;
                ext_s = req.is_unsigned ? {24'h000000, byte_s}
                                        : {{24{byte_s[7]}}, byte_s};
            end
            SZ_H: begin
                misalign_s = req.addr[0];
                ext_s = req.is_unsigned ? {16'h0000, half_s}
                                        : {{16{half_s[15]}}, half_s};
            end
            SZ_W: begin
                misalign_s = (req.addr[1:0] != 2'b00);
                ext_s      = rom_data;
            end
            default: begin
                misalign_s = 1'b1;
                ext_s      = 32'h0000_0000;
            end
        endcase

        if (misalign_s || (last_s > 14'h1FFF)) begin
            err  = 1'b1;
            data = 32'h0000_0000;
        end else begin
            err  = 1'b0;
            data = ext_s;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter for the shared instruction ROM: data loads win by default,
// fetch is forced through after STARVE_LIMIT waiting cycles; 1-cycle response.
module rom_arbiter
    import DEF::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    rom_arbiter_if.slave bus
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;
    logic             gnt_if_s;
    logic             gnt_d_s;
    rom_req_t         req_s;
    word              ld_data_s;
    logic             ld_err_s;

    // Grant decision; nothing is granted while reset is held.
    always_comb begin
        gnt_if_s = 1'b0;
        gnt_d_s  = 1'b0;
        if (!rst_n) begin
            gnt_if_s = 1'b0;
            gnt_d_s  = 1'b0;
        end else if (bus.if_req_valid &&
                     (!bus.d_req_valid || (starve_cnt_r == LIMIT_C))) begin
            gnt_if_s = 1'b1;
        end else if (bus.d_req_valid) begin
            gnt_d_s = 1'b1;
        end else begin
            gnt_if_s = 1'b0;
            gnt_d_s  = 1'b0;
        end
    end

    // Route the granted request to the shared aligner.
    always_comb begin
        if (gnt_d_s) begin
            req_s = '{addr: bus.d_req_addr, size: rom_size_e'(bus.d_req_size),
                      is_unsigned: bus.d_req_unsigned};
        end else begin
            req_s = '{addr: bus.if_req_addr, size: SZ_W, is_unsigned: 1'b1};
        end
    end

    rom_load_align u_align (
        .req      (req_s),
        .rom_data (bus.rom_r_data),
        .data     (ld_data_s),
        .err      (ld_err_s)
    );

    assign bus.if_req_ready = gnt_if_s;
    assign bus.d_req_ready  = gnt_d_s;
    assign bus.rom_addr     = (gnt_if_s || gnt_d_s) ? {req_s.addr[12:2], 2'b00}
                                                     : 13'h0000;

    // Starvation counter: counts IF waiting cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
        end else if (!bus.if_req_valid || gnt_if_s) begin
            starve_cnt_r <= '0;
        end else if (starve_cnt_r != LIMIT_C) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Response registers: one-cycle pulse, payload held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rsp_valid <= 1'b0;
            bus.if_rsp_data  <= 32'h0000_0000;
            bus.if_rsp_err   <= 1'b0;
            bus.d_rsp_valid  <= 1'b0;
            bus.d_rsp_data   <= 32'h0000_0000;
            bus.d_rsp_err    <= 1'b0;
        end else begin
            bus.if_rsp_valid <= gnt_if_s;
            bus.d_rsp_valid  <= gnt_d_s;
            if (gnt_if_s) begin
                bus.if_rsp_data <= ld_data_s;
                bus.if_rsp_err  <= ld_err_s;
            end else begin
                bus.if_rsp_data <= bus.if_rsp_data;
                bus.if_rsp_err  <= bus.if_rsp_err;
            end
            if (gnt_d_s) begin
                bus.d_rsp_data <= ld_data_s;
                bus.d_rsp_err  <= ld_err_s;
            end else begin
                bus.d_rsp_data <= bus.d_rsp_data;
                bus.d_rsp_err  <= bus.d_rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus a randomized
// run against a behavioural model of grants, starvation and load results.
module tb_rom_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass   = 0;
    int   n_checks = 0;
    logic [31:0] rom_mem [0:2047];

    rom_arbiter_if bus ();

    rom_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.rom_r_data = rom_mem[bus.rom_addr[12:2]];

    always #5 clk = ~clk;

    // Expected response for a granted request, straight from the access rules.
    function automatic void ref_resp(input bit is_d, input int addr, input int size,
                                     input bit uns, output logic [31:0] data,
                                     output logic err);
        int     nbytes;
        longint span, val;
        nbytes = is_d ? (1 << size) : 4;
        err    = (is_d && size == 3) || (addr % nbytes != 0) || (addr + nbytes - 1 > 8191);
        data   = 32'h0;
        if (!err) begin
            span = longint'(1) << (8 * nbytes);
            val  = (longint'(rom_mem[addr / 4]) >> (8 * (addr % 4))) % span;
            if (is_d && !uns && nbytes < 4 && val >= span / 2) val = val - span;
            data = val[31:0];
        end
    endfunction

    task automatic idle();
        bus.if_req_valid   = 1'b0;
        bus.if_req_addr    = 13'h0;
        bus.d_req_valid    = 1'b0;
        bus.d_req_addr     = 13'h0;
        bus.d_req_size     = 2'b00;
        bus.d_req_unsigned = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = 13'h0010;
        bus.d_req_valid  = 1'b1; bus.d_req_addr  = 13'h0020;
        bus.d_req_size   = 2'b10; bus.d_req_unsigned = 1'b0;
        #3;
        n_checks++;
        if ({bus.if_req_ready, bus.d_req_ready, bus.rom_addr} !== 15'h0)
            $display("FAIL reset_req: got ready/addr %h want 0", {bus.if_req_ready, bus.d_req_ready, bus.rom_addr});
        else n_pass++;
        n_checks++;
        if ({bus.if_rsp_valid, bus.if_rsp_data, bus.if_rsp_err, bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err} !== 68'h0)
            $display("FAIL reset_rsp: got rsp outputs %h want 0", {bus.if_rsp_valid, bus.if_rsp_data, bus.if_rsp_err, bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err});
        else n_pass++;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_if_only();
        rom_mem[4] = 32'h00A00093;
        @(negedge clk);
        bus.if_req_valid = 1'b1; bus.if_req_addr = 13'h0010;
        #1;
        n_checks++;
        if ({bus.if_req_ready, bus.d_req_ready, bus.rom_addr} !== {2'b10, 13'h0010})
            $display("FAIL if_only_grant: got %h want %h", {bus.if_req_ready, bus.d_req_ready, bus.rom_addr}, {2'b10, 13'h0010});
        else n_pass++;
        @(negedge clk);
        idle();
        n_checks++;
        if ({bus.if_rsp_valid, bus.d_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {3'b100, 32'h00A00093})
            $display("FAIL if_only_rsp: got %h want %h", {bus.if_rsp_valid, bus.d_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}, {3'b100, 32'h00A00093});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({bus.if_rsp_valid, bus.if_rsp_data} !== {1'b0, 32'h00A00093})
            $display("FAIL if_only_hold: got %h want %h", {bus.if_rsp_valid, bus.if_rsp_data}, {1'b0, 32'h00A00093});
        else n_pass++;
    endtask

    task automatic test_d_byte();
        logic [31:0] want;
        rom_mem[64] = 32'h80FFEE11;
        for (int u = 0; u < 2; u++) begin
            want = (u == 1) ? 32'h00000080 : 32'hFFFFFF80;
            @(negedge clk);
            bus.d_req_valid = 1'b1; bus.d_req_addr = 13'h0103;
            bus.d_req_size = 2'b00; bus.d_req_unsigned = u[0];
            #1;
            n_checks++;
            if ({bus.d_req_ready, bus.rom_addr} !== {1'b1, 13'h0100})
                $display("FAIL d_byte_grant: got %h want %h", {bus.d_req_ready, bus.rom_addr}, {1'b1, 13'h0100});
            else n_pass++;
            @(negedge clk);
            idle();
            n_checks++;
            if ({bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data} !== {2'b10, want})
                $display("FAIL d_byte_rsp: got %h want %h", {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, {2'b10, want});
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        int run = 0, max_run = 0;
        logic exp_if;
        @(negedge clk);
        bus.if_req_valid = 1'b1; bus.if_req_addr = 13'h0020;
        bus.d_req_valid = 1'b1; bus.d_req_addr = 13'h0040;
        bus.d_req_size = 2'b10; bus.d_req_unsigned = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_if = (c % 5 == 4);
            n_checks++;
            if ({bus.if_req_ready, bus.d_req_ready} !== {exp_if, ~exp_if})
                $display("FAIL contention_grant: cycle %0d got %b want %b", c, {bus.if_req_ready, bus.d_req_ready}, {exp_if, ~exp_if});
            else n_pass++;
            if (bus.if_req_ready !== 1'b1) run++; else run = 0;
            if (run > max_run) max_run = run;
            @(negedge clk);
            n_checks++;
            if ({bus.if_rsp_valid, bus.d_rsp_valid} !== {exp_if, ~exp_if})
                $display("FAIL contention_rsp: cycle %0d got %b want %b", c, {bus.if_rsp_valid, bus.d_rsp_valid}, {exp_if, ~exp_if});
            else n_pass++;
        end
        idle();
        n_checks++;
        if (max_run !== LIMIT)
            $display("FAIL contention_wait: got max wait %0d want %0d", max_run, LIMIT);
        else n_pass++;
    endtask

    task automatic test_errors();
        bit          t_d   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int          t_adr [4] = '{'h0002, 'h1FFE, 'h0100, 'h1FFE};
        int          t_sz  [4] = '{2, 2, 3, 1};
        logic        t_err [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_dat [4] = '{32'h0, 32'h0, 32'h0, 32'hFFFF8001};
        rom_mem[2047] = 32'h80011234;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (t_d[i]) begin
                bus.d_req_valid = 1'b1; bus.d_req_addr = 13'(t_adr[i]);
                bus.d_req_size = 2'(t_sz[i]); bus.d_req_unsigned = 1'b0;
            end else begin
                bus.if_req_valid = 1'b1; bus.if_req_addr = 13'(t_adr[i]);
            end
            @(negedge clk);
            idle();
            n_checks++;
            if (t_d[i] && {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data} !== {1'b1, t_err[i], t_dat[i]})
                $display("FAIL err_case%0d: got %h want %h", i, {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, {1'b1, t_err[i], t_dat[i]});
            else if (!t_d[i] && {bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {1'b1, t_err[i], t_dat[i]})
                $display("FAIL err_case%0d: got %h want %h", i, {bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}, {1'b1, t_err[i], t_dat[i]});
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        rom_mem[16] = 32'hDEADBEEF;
        @(negedge clk);
        bus.d_req_valid = 1'b1; bus.d_req_addr = 13'h0040;
        bus.d_req_size = 2'b10; bus.d_req_unsigned = 1'b0;
        #1;
        n_checks++;
        if (bus.d_req_ready !== 1'b1) $display("FAIL reset_mid_grant: got %b want 1", bus.d_req_ready);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.if_req_ready, bus.d_req_ready, bus.rom_addr, bus.if_rsp_valid, bus.if_rsp_data, bus.if_rsp_err,
             bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err} !== 83'h0)
            $display("FAIL reset_mid_outputs: got %h want 0", {bus.if_req_ready, bus.d_req_ready, bus.rom_addr,
                     bus.if_rsp_valid, bus.if_rsp_data, bus.if_rsp_err, bus.d_rsp_valid, bus.d_rsp_data, bus.d_rsp_err});
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.d_rsp_valid !== 1'b0) $display("FAIL reset_mid_pulse: got %b want 0", bus.d_rsp_valid);
        else n_pass++;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.d_rsp_valid, bus.d_rsp_data} !== 33'h0)
            $display("FAIL reset_mid_after: got %h want 0", {bus.d_rsp_valid, bus.d_rsp_data});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) rom_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {2'b10, rom_mem[i-1]})
                    $display("FAIL b2b_rsp%0d: got %h want %h", i - 1, {bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}, {2'b10, rom_mem[i-1]});
                else n_pass++;
            end
            if (i < 3) begin
                bus.if_req_valid = 1'b1; bus.if_req_addr = 13'(4 * i);
            end else idle();
        end
        @(negedge clk);
        n_checks++;
        if (bus.if_rsp_valid !== 1'b0) $display("FAIL b2b_end: got %b want 0", bus.if_rsp_valid);
        else n_pass++;
    endtask

    task automatic test_random();
        int waited = 0;
        bit if_v = 0, d_v = 0, keep_if = 0, keep_d = 0, d_uns = 0, gi, gd;
        int if_a = 0, d_a = 0, d_sz = 0;
        logic pend_if = 0, pend_d = 0, he_if = 0, he_d = 0, e;
        logic [31:0] hd_if = 0, hd_d = 0, dat;
        logic [12:0] want_addr;
        for (int i = 0; i < 2048; i++) rom_mem[i] = $urandom;
        @(negedge clk); idle(); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data} !== {pend_if, he_if, hd_if})
                $display("FAIL rand_if_rsp: cycle %0d got %h want %h", c, {bus.if_rsp_valid, bus.if_rsp_err, bus.if_rsp_data}, {pend_if, he_if, hd_if});
            else n_pass++;
            n_checks++;
            if ({bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data} !== {pend_d, he_d, hd_d})
                $display("FAIL rand_d_rsp: cycle %0d got %h want %h", c, {bus.d_rsp_valid, bus.d_rsp_err, bus.d_rsp_data}, {pend_d, he_d, hd_d});
            else n_pass++;
            if (!keep_if) begin
                if_v = ($urandom_range(0, 2) != 0);
                if_a = $urandom_range(0, 8191) & (($urandom_range(0, 3) == 0) ? 'h1FFF : 'h1FFC);
            end
            if (!keep_d) begin
                d_v   = ($urandom_range(0, 2) != 0);
                d_a   = ($urandom_range(0, 4) == 0) ? $urandom_range(8184, 8191) : $urandom_range(0, 8191);
                d_sz  = $urandom_range(0, 3);
                d_uns = $urandom_range(0, 1);
            end
            bus.if_req_valid = if_v; bus.if_req_addr = 13'(if_a);
            bus.d_req_valid = d_v; bus.d_req_addr = 13'(d_a);
            bus.d_req_size = 2'(d_sz); bus.d_req_unsigned = d_uns;
            gi = if_v && (!d_v || waited == LIMIT);
            gd = d_v && !gi;
            want_addr = gi ? 13'(if_a & 'h1FFC) : (gd ? 13'(d_a & 'h1FFC) : 13'h0);
            #1;
            n_checks++;
            if ({bus.if_req_ready, bus.d_req_ready, bus.rom_addr} !== {gi, gd, want_addr})
                $display("FAIL rand_grant: cycle %0d got %h want %h", c, {bus.if_req_ready, bus.d_req_ready, bus.rom_addr}, {gi, gd, want_addr});
            else n_pass++;
            pend_if = gi; pend_d = gd;
            if (gi) begin ref_resp(1'b0, if_a, 2, 1'b1, dat, e); hd_if = dat; he_if = e; end
            if (gd) begin ref_resp(1'b1, d_a, d_sz, d_uns, dat, e); hd_d = dat; he_d = e; end
            if (!if_v || gi) waited = 0; else if (waited < LIMIT) waited++;
            keep_if = if_v && !gi;
            keep_d  = d_v && !gd;
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_if_only();
        test_d_byte();
        test_contention();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
